// File: rtl/lcd_bus_writer.sv
// HD44780-style write-only bus driver: one byte (8-bit bus) or one/two nibbles (4-bit bus)
// per request, with programmable setup/strobe/hold timing and a post-write busy wait.
module lcd_bus_writer #(
  parameter int unsigned BUS4        = 0,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 10,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_WAIT      = 50,
  parameter int unsigned T_WAIT_LONG = 2000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iNibble,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int unsigned CntW = $clog2(T_WAIT_LONG + 1);

  localparam logic [CntW-1:0] LdSetup = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] LdPulse = CntW'(T_PULSE - 1);
  localparam logic [CntW-1:0] LdHold  = CntW'(T_HOLD - 1);
  localparam logic [CntW-1:0] LdWait  = CntW'(T_WAIT - 1);
  localparam logic [CntW-1:0] LdLong  = CntW'(T_WAIT_LONG - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      lo_q, lo_d;
  logic            second_q, second_d;
  logic            long_q, long_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;

  logic accept;
  logic cnt_zero;

  assign accept   = iValid & ready_q;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lo_q     <= 4'h0;
      second_q <= 1'b0;
      long_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      second_q <= second_d;
      long_q   <= long_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      en_q     <= en_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    second_d = second_q;
    long_d   = long_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StSetup;
          cnt_d    = LdSetup;
          lo_d     = iDATA[3:0];
          second_d = (BUS4 != 0) && !iNibble;
          // Clear display / return home need the long busy time.
          long_d   = !iRS && (iDATA[7:2] == 6'd0) && (iDATA != 8'd0);
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StPulse;
          cnt_d   = LdPulse;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_zero) begin
          state_d = StHold;
          cnt_d   = LdHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (second_q) begin
          state_d  = StSetup;
          cnt_d    = LdSetup;
          second_d = 1'b0;
        end else begin
          state_d = StWait;
          cnt_d   = long_q ? LdLong : LdWait;
        end
      end
      StWait: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    done_d  = 1'b0;
    en_d    = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        ready_d = !accept;
        if (accept) begin
          rs_d   = iRS;
          data_d = (BUS4 != 0) ? {iDATA[7:4], 4'h0} : iDATA;
        end
      end
      StSetup: en_d = cnt_zero;
      StPulse: en_d = !cnt_zero;
      StHold: begin
        if (cnt_zero && second_q) begin
          data_d = {lo_q, 4'h0};
        end
      end
      StWait: begin
        ready_d = cnt_zero;
        done_d  = cnt_zero;
      end
      default: ready_d = 1'b0;
    endcase
  end

  assign oReady   = ready_q;
  assign oDone    = done_q;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer: an 8-bit and a 4-bit instance, with expected strobes and
// completion edges queued at request time and checked as the bus activity appears.
module tb_lcd_bus_writer;

  localparam int unsigned S = 1;
  localparam int unsigned P = 3;
  localparam int unsigned H = 1;
  localparam int unsigned W = 4;
  localparam int unsigned WL = 8;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         start;
    int         width;
  } pulse_t;

  logic iclk;
  logic irst;
  logic [7:0] d8_data, d4_data;
  logic d8_rs, d4_rs, d8_nib, d4_nib, d8_valid, d4_valid;
  logic r8_ready, r8_done, r8_rw, r8_en, r8_rs;
  logic r4_ready, r4_done, r4_rw, r4_en, r4_rs;
  logic [7:0] r8_data, r4_data;

  bit sel;
  logic m_ready, m_done, m_en, m_rs;
  logic [7:0] m_data;

  pulse_t pulse_q[$];
  int     done_exp_q[$];
  int     checks = 0;
  int     errors = 0;

  lcd_bus_writer #(
    .BUS4(0), .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_WAIT(W), .T_WAIT_LONG(WL)
  ) u_dut8 (
    .iCLK(iclk), .iRST(irst), .iDATA(d8_data), .iRS(d8_rs), .iNibble(d8_nib),
    .iValid(d8_valid), .oReady(r8_ready), .oDone(r8_done), .LCD_DATA(r8_data),
    .LCD_RW(r8_rw), .LCD_EN(r8_en), .LCD_RS(r8_rs)
  );

  lcd_bus_writer #(
    .BUS4(1), .T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_WAIT(W), .T_WAIT_LONG(WL)
  ) u_dut4 (
    .iCLK(iclk), .iRST(irst), .iDATA(d4_data), .iRS(d4_rs), .iNibble(d4_nib),
    .iValid(d4_valid), .oReady(r4_ready), .oDone(r4_done), .LCD_DATA(r4_data),
    .LCD_RW(r4_rw), .LCD_EN(r4_en), .LCD_RS(r4_rs)
  );

  assign m_ready = sel ? r4_ready : r8_ready;
  assign m_done  = sel ? r4_done  : r8_done;
  assign m_en    = sel ? r4_en    : r8_en;
  assign m_rs    = sel ? r4_rs    : r8_rs;
  assign m_data  = sel ? r4_data  : r8_data;

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit s, input logic [7:0] d, input logic rs, input logic nib,
                       input logic v);
    if (s) begin
      d4_data = d; d4_rs = rs; d4_nib = nib; d4_valid = v;
    end else begin
      d8_data = d; d8_rs = rs; d8_nib = nib; d8_valid = v;
    end
  endtask

  // Expected bus activity straight from the timing rules: edges counted from acceptance.
  task automatic push_exp(input bit s, input logic [7:0] d, input logic rs, input logic nib);
    pulse_t p;
    int n;
    bit lng;
    lng = !rs && (d[7:2] == 6'd0) && (d != 8'd0);
    n   = (s && !nib) ? 2 : 1;
    p.rs = rs; p.start = 1 + S; p.width = P;
    p.data = s ? {d[7:4], 4'h0} : d;
    pulse_q.push_back(p);
    if (n == 2) begin
      p.data  = {d[3:0], 4'h0};
      p.start = 1 + 2 * S + P + H;
      pulse_q.push_back(p);
    end
    done_exp_q.push_back(n * (S + P + H) + (lng ? WL : W) + 1);
  endtask

  task automatic watch(input bit s, input bit keep_valid);
    pulse_t p;
    int start, done_e;
    logic [7:0] pdata;
    logic prs, en_prev, unstable, ready_bad;
    en_prev = 1'b0; unstable = 1'b0; ready_bad = 1'b0;
    start = 0; done_e = -1; pdata = 8'h00; prs = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge iclk);
      if (j == 1) begin
        chk("ready_low_after_accept", m_ready, 1'b0);
        chk("done_low_after_accept", m_done, 1'b0);
        // Scramble inputs while busy; the in-flight transfer must not notice.
        if (s) begin
          d4_data = ~d4_data; d4_rs = ~d4_rs; d4_nib = ~d4_nib;
          if (!keep_valid) d4_valid = 1'b0;
        end else begin
          d8_data = ~d8_data; d8_rs = ~d8_rs; d8_nib = ~d8_nib;
          if (!keep_valid) d8_valid = 1'b0;
        end
      end
      if (m_en && !en_prev) begin
        start = j; pdata = m_data; prs = m_rs;
      end else if (en_prev && (m_data !== pdata || m_rs !== prs)) begin
        unstable = 1'b1;
      end
      if (en_prev && !m_en) begin
        chk("pulse_expected", pulse_q.size() > 0, 1'b1);
        if (pulse_q.size() > 0) begin
          p = pulse_q.pop_front();
          chk("pulse_data", pdata, p.data);
          chk("pulse_rs", prs, p.rs);
          chk("pulse_start_edge", start, p.start);
          chk("pulse_width", j - start, p.width);
          chk("bus_stable", unstable, 1'b0);
        end
      end
      if (!m_done && m_ready) ready_bad = 1'b1;
      en_prev = m_en;
      if (m_done) begin
        done_e = j;
        break;
      end
    end
    chk("ready_low_while_busy", ready_bad, 1'b0);
    chk("ready_at_done", m_ready, 1'b1);
    chk("done_edge", done_e, done_exp_q.pop_front());
    chk("all_pulses_seen", pulse_q.size(), 0);
  endtask

  task automatic req(input bit s, input logic [7:0] d, input logic rs, input logic nib,
                     input bit keep_valid);
    push_exp(s, d, rs, nib);
    drive(s, d, rs, nib, 1'b1);
    @(posedge iclk);
    watch(s, keep_valid);
  endtask

  initial begin
    logic no_done;
    sel  = 1'b0;
    irst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge iclk);
    chk("rst_ready8", r8_ready, 1'b0);
    chk("rst_done8", r8_done, 1'b0);
    chk("rst_en8", r8_en, 1'b0);
    chk("rst_rs8", r8_rs, 1'b0);
    chk("rst_data8", r8_data, 8'h00);
    chk("rst_rw8", r8_rw, 1'b0);
    chk("rst_en4", r4_en, 1'b0);
    chk("rst_ready4", r4_ready, 1'b0);
    irst = 1'b0;
    @(negedge iclk);
    chk("ready8_after_rst", r8_ready, 1'b1);
    chk("ready4_after_rst", r4_ready, 1'b1);

    // 8-bit bus: data write, then idle hold of last bus value
    sel = 1'b0;
    req(1'b0, 8'h41, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge iclk);
    chk("idle_data_held", r8_data, 8'h41);
    chk("idle_rs_held", r8_rs, 1'b1);
    chk("idle_ready", r8_ready, 1'b1);
    chk("done_single_cycle", r8_done, 1'b0);
    // clear/home detection boundaries
    req(1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    req(1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    req(1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
    req(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    req(1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("rw_low8", r8_rw, 1'b0);

    // 4-bit bus
    sel = 1'b1;
    @(negedge iclk);
    req(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    req(1'b1, 8'h30, 1'b0, 1'b1, 1'b0);
    @(negedge iclk);
    req(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("rw_low4", r4_rw, 1'b0);

    // back-to-back with iValid held high
    sel = 1'b0;
    @(negedge iclk);
    req(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    req(1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    req(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);

    // reset during the enable pulse
    @(negedge iclk);
    drive(1'b0, 8'h7E, 1'b1, 1'b0, 1'b1);
    @(posedge iclk);
    repeat (2) @(negedge iclk);
    chk("en_high_before_rst", r8_en, 1'b1);
    #2;
    irst = 1'b1;
    d8_valid = 1'b0;
    #1;
    chk("en_dropped_in_rst", r8_en, 1'b0);
    chk("ready_low_in_rst", r8_ready, 1'b0);
    chk("data_zero_in_rst", r8_data, 8'h00);
    chk("rs_zero_in_rst", r8_rs, 1'b0);
    repeat (2) @(negedge iclk);
    irst = 1'b0;
    @(negedge iclk);
    chk("ready_after_midrst", r8_ready, 1'b1);
    no_done = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (r8_done) no_done = 1'b0;
      @(negedge iclk);
    end
    chk("no_done_after_abort", no_done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_writer.md
LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 SHALL have parameter BUS4, default 0, meaning 1 = HD44780 4-bit bus (nibbles on LCD_DATA[7:4]) and 0 = 8-bit bus.
REQ-002 SHALL have parameter T_SETUP, default 2, meaning RS/data setup cycles before EN rises (legal range >= 1).
REQ-003 SHALL have parameter T_PULSE, default 10, meaning EN high cycles (legal range >= 1).
REQ-004 SHALL have parameter T_HOLD, default 2, meaning cycles with EN low and data held after EN falls (legal range >= 1).
REQ-005 SHALL have parameter T_WAIT, default 50, meaning post-transfer busy cycles for normal writes (legal range >= 1).
REQ-006 SHALL have parameter T_WAIT_LONG, default 2000, meaning post-transfer busy cycles for clear/home commands (legal range >= T_WAIT).
REQ-007 SHALL have port iCLK  in  1  clock; all state changes on its rising edge.
REQ-008 SHALL have port iRST  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port iDATA  in  8  byte to write.
REQ-010 SHALL have port iRS  in  1  register select (0 command, 1 data).
REQ-011 SHALL have port iNibble  in  1  when BUS4=1, transfer iDATA[7:4] only (init sequence); ignored when BUS4=0.
REQ-012 SHALL have port iValid  in  1  request valid.
REQ-013 SHALL have port oReady  out  1  block idle; a request is accepted on an edge where iValid & oReady.
REQ-014 SHALL have port oDone  out  1  one-cycle pulse at completion of a request.
REQ-015 SHALL have port LCD_DATA  out  8  LCD data bus.
REQ-016 SHALL have port LCD_RW  out  1  tied 0 (write-only).
REQ-017 SHALL have port LCD_EN  out  1  LCD enable strobe.
REQ-018 SHALL have port LCD_RS  out  1  LCD register select.

Function
REQ-019 SHALL latch iDATA, iRS and iNibble at acceptance; input changes after acceptance SHALL NOT affect the transfer.
REQ-020 SHALL implement states IDLE, SETUP, PULSE, HOLD and WAIT, with all outputs driven from registers.
REQ-021 SHALL perform each nibble/byte transfer as: SETUP for T_SETUP cycles (EN=0), then PULSE for T_PULSE cycles (EN=1), then HOLD for T_HOLD cycles (EN=0).
REQ-022 SHALL keep LCD_RS and LCD_DATA stable from the first SETUP cycle to the last HOLD cycle of each transfer.
REQ-023 SHALL, when BUS4=0, drive the latched byte on LCD_DATA[7:0] and perform a single transfer.
REQ-024 SHALL, when BUS4=1 and iNibble=0, transfer the high nibble, then the low nibble, each on LCD_DATA[7:4] with LCD_DATA[3:0]=0; HOLD of the first nibble SHALL go directly to SETUP of the second.
REQ-025 SHALL, when BUS4=1 and iNibble=1, transfer the high nibble only.
REQ-026 SHALL, after the final HOLD, enter WAIT for T_WAIT_LONG cycles if latched iRS=0 and iDATA[7:2]=0 with iDATA!=0 (clear/home), otherwise for T_WAIT cycles.
REQ-027 SHALL, on the edge ending WAIT, enter IDLE, assert oReady=1 and pulse oDone=1 for exactly one cycle.
REQ-028 SHALL hold oReady=0 from the acceptance edge until return to IDLE, and ignore iValid while oReady=0.
REQ-029 SHALL accept a new request in the oDone cycle if iValid=1 (back-to-back, no idle gap).
REQ-030 SHALL, with 8-bit or single-nibble transfers, assert oDone exactly T_SETUP+T_PULSE+T_HOLD+Twait+1 edges after the acceptance edge, where Twait is the WAIT length of REQ-026; a 4-bit two-nibble transfer SHALL add T_SETUP+T_PULSE+T_HOLD.
REQ-031 SHALL size the timing counter as $clog2(T_WAIT_LONG+1) bits with no wrap-around at any legal parameter value.
REQ-032 SHALL keep LCD_DATA and LCD_RS at their last driven values while IDLE.

Reset
REQ-033 SHALL, while iRST=1, force state=IDLE, oReady=0, oDone=0, LCD_EN=0, LCD_RS=0, LCD_DATA=0 and counter=0, with LCD_RW=0 at all times.
REQ-034 SHALL set oReady=1 on the first iCLK edge after iRST deasserts.
REQ-035 SHALL, on reset asserted mid-transfer (including while LCD_EN=1), drop LCD_EN immediately, discard the request and not issue oDone for it.

Verification
REQ-036 SHALL be verified with 8-bit mode, T=1/3/1/4/8, and iDATA=8'h41, iRS=1 accepted at edge k -> EN high at edges k+2..k+4, oDone pulse at edge k+10, LCD_DATA=8'h41 and LCD_RS=1 throughout.
REQ-037 SHALL be verified with the same parameters and command 8'h01, iRS=0 -> WAIT of 8 cycles, oDone at edge k+14.
REQ-038 SHALL be verified with BUS4=1, byte 8'hA5 -> LCD_DATA[7:4]=4'hA then 4'h5, two EN pulses of 3 cycles each, LCD_DATA[3:0]=0, and oDone at edge k+15.
REQ-039 SHALL be verified with BUS4=1, iNibble=1 and 8'h30 -> a single EN pulse with LCD_DATA=8'h30, and oDone at edge k+10.
REQ-040 SHALL be verified with iValid held high for 3 requests -> each accepted in the previous oDone cycle, and iDATA changes while busy do not corrupt the in-flight transfer.
REQ-041 SHALL be verified with iRST pulsed during PULSE -> LCD_EN=0 immediately, no oDone, and oReady=1 one edge after release.
